// File: rtl/lsu_mem_stage.sv
// RV32I load/store memory stage: byte/half/word access with read-modify-write sub-word stores.
// Optional LSU_MISALIGN_ERR_EN flags misaligned H/W accesses as errors instead of aligning them.
module lsu_mem_stage #(
    parameter int MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_f3_ok;
    logic        w_range_err;
    logic        w_misal;
    logic        w_err;
    logic        w_word_st;
    logic        w_we;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    always_comb begin
        w_f3_ok = 1'b0;
        unique case (r_funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = !r_store;
            default:                w_f3_ok = 1'b0;
        endcase
    end

    assign w_range_err = (r_addr[31:2] >= LP_WORDS);

`ifdef LSU_MISALIGN_ERR_EN
    assign w_misal = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                     ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`else
    assign w_misal = 1'b0;
`endif

    assign w_err     = !w_f3_ok || w_range_err || w_misal;
    assign w_word_st = r_store && (r_funct3 == 3'b010);

    // Lane selection ignores the low address bits that misalignment would use.
    always_comb begin
        w_byte = mem_rdata[7:0];
        unique case (r_addr[1:0])
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            2'd3: w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
    end

    assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_load = mem_rdata;
        unique case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_merge = mem_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            unique case (r_addr[1:0])
                2'd0: w_merge[7:0]   = r_wdata[7:0];
                2'd1: w_merge[15:8]  = r_wdata[7:0];
                2'd2: w_merge[23:16] = r_wdata[7:0];
                2'd3: w_merge[31:24] = r_wdata[7:0];
                default: w_merge = mem_rdata;
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    // Decoded from state so that reset removes the write strobe at once.
    assign w_we = ((r_state == S_ACCESS) && w_word_st && !w_err) ||
                  (r_state == S_WRITE);

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_addr   = {2'b00, r_addr[31:2]};
    assign mem_we     = w_we;
    assign mem_wdata  = !w_we ? 32'h0 :
                        (r_state == S_WRITE) ? r_merge : r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_store      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_merge      <= 32'h0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (w_err) begin
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'h0;
                        r_state      <= S_RESP;
                    end else if (!r_store) begin
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load;
                        r_state      <= S_RESP;
                    end else if (w_word_st) begin
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'h0;
                        r_state      <= S_RESP;
                    end else begin
                        r_merge <= w_merge;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage with a behavioural data memory.
// Expectations for misaligned accesses follow LSU_MISALIGN_ERR_EN.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_mem_stage #(.MEM_WORDS(512)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:511];
    assign mem_rdata = (mem_addr < 32'd512) ? mem[mem_addr[8:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we && (mem_addr < 32'd512)) mem[mem_addr[8:0]] <= mem_wdata;
    end

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          gap;
        int          we;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int we_cnt = 0;
    bit seen = 0;
    int first_cyc = 0;
    logic [31:0] first_d;
    logic first_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) we_cnt = we_cnt + 1;
        checks = checks + 1;
        if (mem_we && (req_ready || resp_valid)) begin
            errors = errors + 1;
            $display("FAIL we_idle_resp: mem_we=%b req_ready=%b resp_valid=%b want mem_we=0",
                     mem_we, req_ready, resp_valid);
        end
    end

    // Monitor: checks hold-stability while stalled and pops on handshake.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            checks = checks + 1;
            if (req_ready !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL ready_in_resp: got %b want 0", req_ready);
            end
            if (!seen) begin
                seen = 1;
                first_cyc = cyc;
                first_d = resp_rdata;
                first_e = resp_err;
            end else begin
                checks = checks + 1;
                if (resp_rdata !== first_d || resp_err !== first_e) begin
                    errors = errors + 1;
                    $display("FAIL resp_stable: got %h/%b want %h/%b",
                             resp_rdata, resp_err, first_d, first_e);
                end
            end
            if (resp_ready) begin
                if (q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_resp: got rdata %h err %b want none",
                             resp_rdata, resp_err);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    checks = checks + 1;
                    if (resp_err !== x.e) begin
                        errors = errors + 1;
                        $display("FAIL resp_err: got %b want %b", resp_err, x.e);
                    end
                    if (!x.e) begin
                        checks = checks + 1;
                        if (resp_rdata !== x.d) begin
                            errors = errors + 1;
                            $display("FAIL resp_rdata: got %h want %h", resp_rdata, x.d);
                        end
                    end
                    checks = checks + 1;
                    if (first_cyc - last_acc !== x.gap) begin
                        errors = errors + 1;
                        $display("FAIL latency: got %0d want %0d",
                                 first_cyc - last_acc, x.gap);
                    end
                    checks = checks + 1;
                    if (we_cnt !== x.we) begin
                        errors = errors + 1;
                        $display("FAIL we_count: got %0d want %0d", we_cnt, x.we);
                    end
                end
                seen = 0;
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e,
                         input int gap, input int we, input bit push);
        int t;
        exp_t x;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            errors = errors + 1;
            $display("FAIL ready_timeout: got req_ready=0 want 1");
        end
        req_valid = 1'b1;
        req_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        if (push) begin
            x.d = exp_d;
            x.e = exp_e;
            x.gap = gap;
            x.we = we;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        last_acc = cyc;
        we_cnt = 0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL resp_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic op(input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e,
                      input int gap, input int we);
        issue(st, f3, a, wd, exp_d, exp_e, gap, we, 1'b1);
        wait_done();
    endtask

    task automatic chk_mem(input string nm, input int idx, input logic [31:0] want);
        checks = checks + 1;
        if (mem[idx] !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", nm, mem[idx], want);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        int t;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[1] = 32'hCAFEF00D;
        mem[8] = 32'h11223344;
        mem[511] = 32'h5A5A5A5A;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk32("rst_resp_rdata", resp_rdata, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;

        // store word / load word / byte merge
        op(1, 3'b010, 32'h10, 32'h12345678, 32'h0, 0, 1, 1);
        chk_mem("sw_word4", 4, 32'h12345678);
        op(0, 3'b010, 32'h10, 32'h0, 32'h12345678, 0, 1, 0);
        op(1, 3'b000, 32'h11, 32'h000000AB, 32'h0, 0, 2, 1);
        chk_mem("sb_word4", 4, 32'h1234AB78);
        op(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAB, 0, 1, 0);
        op(0, 3'b100, 32'h11, 32'h0, 32'h000000AB, 0, 1, 0);
        op(0, 3'b001, 32'h12, 32'h0, 32'h00001234, 0, 1, 0);
        op(0, 3'b101, 32'h10, 32'h0, 32'h0000AB78, 0, 1, 0);
        op(0, 3'b001, 32'h10, 32'h0, 32'hFFFFAB78, 0, 1, 0);
        op(1, 3'b000, 32'h13, 32'hFFFFFF80, 32'h0, 0, 2, 1);
        chk_mem("sb_top_word4", 4, 32'h8034AB78);
        op(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, 1, 0);
        op(1, 3'b001, 32'h16, 32'h0000C0DE, 32'h0, 0, 2, 1);
        chk_mem("sh_word5", 5, 32'hC0DE0000);

        // range and funct3 errors
        op(0, 3'b010, 32'h802, 32'h0, 32'h0, 1, 1, 0);
        op(1, 3'b010, 32'h800, 32'hDEADBEEF, 32'h0, 1, 1, 0);
        op(0, 3'b010, 32'h7FC, 32'h0, 32'h5A5A5A5A, 0, 1, 0);
        op(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 0);
        op(1, 3'b100, 32'h10, 32'h000000FF, 32'h0, 1, 1, 0);
        op(1, 3'b101, 32'h10, 32'h0000FFFF, 32'h0, 1, 1, 0);
        chk_mem("err_no_write", 4, 32'h8034AB78);

`ifdef LSU_MISALIGN_ERR_EN
        op(0, 3'b010, 32'h6, 32'h0, 32'h0, 1, 1, 0);
        op(0, 3'b001, 32'h5, 32'h0, 32'h0, 1, 1, 0);
        op(0, 3'b101, 32'h7, 32'h0, 32'h0, 1, 1, 0);
        op(1, 3'b010, 32'h6, 32'h01020304, 32'h0, 1, 1, 0);
        chk_mem("misal_no_write", 1, 32'hCAFEF00D);
`else
        op(0, 3'b010, 32'h6, 32'h0, 32'hCAFEF00D, 0, 1, 0);
        op(0, 3'b001, 32'h5, 32'h0, 32'hFFFFF00D, 0, 1, 0);
        op(0, 3'b101, 32'h7, 32'h0, 32'h0000CAFE, 0, 1, 0);
        op(1, 3'b010, 32'h6, 32'h01020304, 32'h0, 0, 1, 1);
        chk_mem("misal_aligned_write", 1, 32'h01020304);
`endif

        // back-pressure: hold resp_ready low 5 cycles
        resp_ready = 1'b0;
        issue(0, 3'b010, 32'h10, 32'h0, 32'h8034AB78, 0, 1, 0, 1'b1);
        t = 0;
        while (!resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk1("stall_valid_seen", resp_valid, 1'b1);
        repeat (5) @(negedge clk);
        chk1("stall_valid_held", resp_valid, 1'b1);
        chk1("stall_ready_low", req_ready, 1'b0);
        resp_ready = 1'b1;
        wait_done();

        // reset during WRITE of SH 0xBEEF @0x20
        issue(1, 3'b001, 32'h20, 32'h0000BEEF, 32'h0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        chk1("write_we_high", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_we_drop", mem_we, 1'b0);
        chk1("rst_valid_low", resp_valid, 1'b0);
        chk1("rst_idle", req_ready, 1'b1);
        chk32("rst_addr_zero", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk1("post_rst_valid", resp_valid, 1'b0);
        chk_mem("rst_word8_kept", 8, 32'h11223344);
        op(0, 3'b010, 32'h20, 32'h0, 32'h11223344, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
